// File: rtl/adder_acc_reg_if.sv
// Operand/result bundle for adder_acc_reg: the source drives operands, the unit returns the result and flags.
interface adder_acc_reg_if #(parameter int WIDTH = 4);
  logic             en;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [1:0]       mode;
  logic [WIDTH-1:0] q;
  logic             co;
  logic             ovf;
  logic             zero;
  logic             vld;

  modport master (output en, A, B, Cin, mode, input q, co, ovf, zero, vld);
  modport slave  (input en, A, B, Cin, mode, output q, co, ovf, zero, vld);
endinterface

// File: rtl/adder_acc_reg.sv
// Registered add/subtract/accumulate unit with carry, overflow, zero flags and a result strobe.
// Optional input stage (PIPE=1) adds one cycle of latency without breaking accumulate chains.
module adder_acc_reg #(
  parameter int WIDTH = 4,
  parameter int PIPE  = 0
) (
  input logic            clk,
  input logic            reset,
  adder_acc_reg_if.slave bus
);
  localparam logic [1:0] MODE_ADD    = 2'd0;
  localparam logic [1:0] MODE_SUB    = 2'd1;
  localparam logic [1:0] MODE_ACC    = 2'd2;
  localparam logic [1:0] MODE_ACCSUB = 2'd3;

  logic [WIDTH-1:0] s_a, s_b;
  logic             s_cin, s_vld;
  logic [1:0]       s_mode;

  logic [WIDTH-1:0] q_r;
  logic             co_r, ovf_r, zero_r, vld_r;

  logic [WIDTH-1:0] add_x, add_y;
  logic             add_c;
  logic [WIDTH:0]   sum;
  logic             sum_ovf;

  if (PIPE != 0) begin : g_pipe
    always_ff @(posedge clk) begin
      if (reset) begin
        s_vld  <= 1'b0;
        s_a    <= '0;
        s_b    <= '0;
        s_cin  <= 1'b0;
        s_mode <= MODE_ADD;
      end else begin
        s_vld  <= bus.en;
        s_a    <= bus.A;
        s_b    <= bus.B;
        s_cin  <= bus.Cin;
        s_mode <= bus.mode;
      end
    end
  end else begin : g_nopipe
    always_comb begin
      s_vld  = bus.en;
      s_a    = bus.A;
      s_b    = bus.B;
      s_cin  = bus.Cin;
      s_mode = bus.mode;
    end
  end

  // Accumulate modes read the live q, so chained ops need no bubble even with PIPE=1.
  always_comb begin
    add_x = s_a;
    add_y = s_b;
    add_c = s_cin;
    case (s_mode)
      MODE_ADD:    begin add_x = s_a; add_y = s_b;  add_c = s_cin;  end
      MODE_SUB:    begin add_x = s_a; add_y = ~s_b; add_c = ~s_cin; end
      MODE_ACC:    begin add_x = q_r; add_y = s_a;  add_c = s_cin;  end
      MODE_ACCSUB: begin add_x = q_r; add_y = ~s_a; add_c = ~s_cin; end
      default:     begin add_x = s_a; add_y = s_b;  add_c = s_cin;  end
    endcase
    sum     = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_c};
    sum_ovf = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_r    <= '0;
      co_r   <= 1'b0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b1;
      vld_r  <= 1'b0;
    end else begin
      vld_r <= s_vld;
      if (s_vld) begin
        q_r    <= sum[WIDTH-1:0];
        co_r   <= sum[WIDTH];
        ovf_r  <= sum_ovf;
        zero_r <= (sum[WIDTH-1:0] == '0);
      end
    end
  end

  assign bus.q    = q_r;
  assign bus.co   = co_r;
  assign bus.ovf  = ovf_r;
  assign bus.zero = zero_r;
  assign bus.vld  = vld_r;
endmodule

// File: tb/tb_adder_acc_reg.sv
// Directed bench for adder_acc_reg: a WIDTH=4/PIPE=0 instance and a WIDTH=8/PIPE=1 instance.
module tb_adder_acc_reg;
  logic clk = 1'b0;
  logic rst0, rst1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder_acc_reg_if #(.WIDTH(4)) b0 ();
  adder_acc_reg_if #(.WIDTH(8)) b1 ();

  adder_acc_reg #(.WIDTH(4), .PIPE(0)) dut0 (.clk(clk), .reset(rst0), .bus(b0.slave));
  adder_acc_reg #(.WIDTH(8), .PIPE(1)) dut1 (.clk(clk), .reset(rst1), .bus(b1.slave));

  // Output vector order: {q, co, ovf, zero, vld}
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic en, input logic [1:0] mode, input logic [3:0] a,
                        input logic [3:0] b, input logic cin);
    b0.en = en; b0.mode = mode; b0.A = a; b0.B = b; b0.Cin = cin;
  endtask

  task automatic drive1(input logic en, input logic [1:0] mode, input logic [7:0] a,
                        input logic [7:0] b, input logic cin);
    b1.en = en; b1.mode = mode; b1.A = a; b1.B = b; b1.Cin = cin;
  endtask

  task automatic test_reset;
    rst0 = 1'b1; rst1 = 1'b1;
    drive0(1'b0, 2'd0, 4'h0, 4'h0, 1'b0);
    drive1(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
    tick; tick;
    checks++;
    if ({b0.q, b0.co, b0.ovf, b0.zero, b0.vld} !== {4'h0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_w4 got=%b exp=%b", {b0.q, b0.co, b0.ovf, b0.zero, b0.vld}, 8'b0000_0010);
    end
    checks++;
    if ({b1.q, b1.co, b1.ovf, b1.zero, b1.vld} !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_w8 got=%b exp=%b", {b1.q, b1.co, b1.ovf, b1.zero, b1.vld}, 12'b0000_0000_0010);
    end
    rst0 = 1'b0; rst1 = 1'b0;
  endtask

  task automatic test_add;
    drive0(1'b1, 2'd0, 4'b1111, 4'b1111, 1'b0);
    tick;
    checks++;
    if ({b0.q, b0.co, b0.ovf, b0.zero, b0.vld} !== 8'b1110_1001) begin
      failures++;
      $display("FAIL add_ff got=%b exp=%b", {b0.q, b0.co, b0.ovf, b0.zero, b0.vld}, 8'b1110_1001);
    end
    drive0(1'b1, 2'd0, 4'b0110, 4'b0001, 1'b0);
    tick;
    checks++;
    if ({b0.q, b0.co, b0.ovf, b0.zero, b0.vld} !== 8'b0111_0001) begin
      failures++;
      $display("FAIL add_6_1 got=%b exp=%b", {b0.q, b0.co, b0.ovf, b0.zero, b0.vld}, 8'b0111_0001);
    end
    drive0(1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
    tick;
    checks++;
    if ({b0.q, b0.vld} !== 5'b0111_0) begin
      failures++;
      $display("FAIL add_vld_pulse got=%b exp=%b", {b0.q, b0.vld}, 5'b0111_0);
    end
  endtask

  task automatic test_sub;
    drive0(1'b1, 2'd1, 4'b0001, 4'b0010, 1'b0);
    tick;
    checks++;
    if ({b0.q, b0.co, b0.ovf, b0.zero, b0.vld} !== 8'b1111_0001) begin
      failures++;
      $display("FAIL sub_borrow got=%b exp=%b", {b0.q, b0.co, b0.ovf, b0.zero, b0.vld}, 8'b1111_0001);
    end
    drive0(1'b1, 2'd1, 4'b0111, 4'b1000, 1'b0);
    tick;
    checks++;
    if ({b0.q, b0.co, b0.ovf, b0.zero, b0.vld} !== 8'b1111_0101) begin
      failures++;
      $display("FAIL sub_ovf got=%b exp=%b", {b0.q, b0.co, b0.ovf, b0.zero, b0.vld}, 8'b1111_0101);
    end
  endtask

  task automatic test_acc;
    logic [7:0] exp_tab [4];
    exp_tab[0] = 8'b0101_0001;
    exp_tab[1] = 8'b1010_0101;
    exp_tab[2] = 8'b1111_0001;
    exp_tab[3] = 8'b0000_1011;
    rst0 = 1'b1;
    drive0(1'b0, 2'd0, 4'h0, 4'h0, 1'b0);
    tick;
    rst0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive0(1'b1, 2'd2, 4'b0101, 4'b1010, 1'b0);
      else       drive0(1'b1, 2'd3, 4'b1111, 4'b0000, 1'b0);
      tick;
      checks++;
      if ({b0.q, b0.co, b0.ovf, b0.zero, b0.vld} !== exp_tab[i]) begin
        failures++;
        $display("FAIL acc_step%0d got=%b exp=%b", i, {b0.q, b0.co, b0.ovf, b0.zero, b0.vld}, exp_tab[i]);
      end
    end
  endtask

  task automatic test_hold;
    // 9 + 8 + 1 = 0x12: q=2, co=1, negative+negative gives positive so ovf=1
    drive0(1'b1, 2'd0, 4'b1001, 4'b1000, 1'b1);
    tick;
    checks++;
    if ({b0.q, b0.co, b0.ovf, b0.zero, b0.vld} !== 8'b0010_1101) begin
      failures++;
      $display("FAIL hold_setup got=%b exp=%b", {b0.q, b0.co, b0.ovf, b0.zero, b0.vld}, 8'b0010_1101);
    end
    drive0(1'b0, 2'd2, 4'b1111, 4'b1111, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if ({b0.q, b0.co, b0.ovf, b0.zero, b0.vld} !== 8'b0010_1100) begin
        failures++;
        $display("FAIL hold_cyc%0d got=%b exp=%b", i, {b0.q, b0.co, b0.ovf, b0.zero, b0.vld}, 8'b0010_1100);
      end
    end
  endtask

  task automatic test_reset_priority;
    rst0 = 1'b1;
    drive0(1'b1, 2'd0, 4'b1111, 4'b1111, 1'b0);
    tick;
    checks++;
    if ({b0.q, b0.co, b0.ovf, b0.zero, b0.vld} !== 8'b0000_0010) begin
      failures++;
      $display("FAIL rst_prio got=%b exp=%b", {b0.q, b0.co, b0.ovf, b0.zero, b0.vld}, 8'b0000_0010);
    end
    rst0 = 1'b0;
    tick;
    checks++;
    if ({b0.q, b0.co, b0.ovf, b0.zero, b0.vld} !== 8'b1110_1001) begin
      failures++;
      $display("FAIL rst_release got=%b exp=%b", {b0.q, b0.co, b0.ovf, b0.zero, b0.vld}, 8'b1110_1001);
    end
    drive0(1'b0, 2'd0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [7:0]  a_tab [3];
    logic [11:0] exp_tab [5];
    a_tab[0] = 8'h80; a_tab[1] = 8'h80; a_tab[2] = 8'h01;
    exp_tab[0] = {8'h00, 4'b0010};
    exp_tab[1] = {8'h80, 4'b0001};
    exp_tab[2] = {8'h00, 4'b1111};
    exp_tab[3] = {8'h01, 4'b0001};
    exp_tab[4] = {8'h01, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive1(1'b1, 2'd2, a_tab[i], 8'hff, 1'b0);
      else       drive1(1'b0, 2'd2, 8'h00, 8'h00, 1'b0);
      tick;
      checks++;
      if ({b1.q, b1.co, b1.ovf, b1.zero, b1.vld} !== exp_tab[i]) begin
        failures++;
        $display("FAIL pipe_b2b_%0d got=%b exp=%b", i, {b1.q, b1.co, b1.ovf, b1.zero, b1.vld}, exp_tab[i]);
      end
    end
  endtask

  task automatic test_pipe_reset;
    drive1(1'b1, 2'd0, 8'h10, 8'h20, 1'b0);
    tick;
    drive1(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
    rst1 = 1'b1;
    tick;
    checks++;
    if ({b1.q, b1.co, b1.ovf, b1.zero, b1.vld} !== {8'h00, 4'b0010}) begin
      failures++;
      $display("FAIL pipe_rst got=%b exp=%b", {b1.q, b1.co, b1.ovf, b1.zero, b1.vld}, {8'h00, 4'b0010});
    end
    rst1 = 1'b0;
    tick;
    checks++;
    if ({b1.q, b1.co, b1.ovf, b1.zero, b1.vld} !== {8'h00, 4'b0010}) begin
      failures++;
      $display("FAIL pipe_rst_discard got=%b exp=%b", {b1.q, b1.co, b1.ovf, b1.zero, b1.vld}, {8'h00, 4'b0010});
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_acc;
    test_hold;
    test_reset_priority;
    test_back_to_back;
    test_pipe_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
